// File: rtl/spi_frame_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_frame_pkg : opcodes, FSM encoding and status-byte layout for the       |
// |                 SPI frame engine.                       Rev 1.0            |
// +----------------------------------------------------------------------------+
package spi_frame_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_WRCH = 4'h1;
  localparam logic [3:0] OP_RDCH = 4'h2;
  localparam logic [3:0] OP_RUN  = 4'h3;
  localparam logic [3:0] OP_RES  = 4'h4;
  localparam logic [3:0] OP_STAT = 4'h5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SIZE  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_RUN   = 3'd4,
    ST_RES   = 3'd5
  } state_t;

  localparam int STAT_RUN_BIT   = 7;
  localparam int STAT_ERR_BIT   = 6;
  localparam int STAT_STATE_LSB = 3;

  localparam logic [7:0] RUN_BUSY = 8'h40;
  localparam logic [7:0] RUN_DONE = 8'h80;

endpackage
`default_nettype wire

// File: rtl/spi_word_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_word_serializer : loads a result word and presents it MSB byte first,  |
// |                       one byte per advance, with a last-byte flag. Rev 1.0 |
// +----------------------------------------------------------------------------+
module spi_word_serializer #(
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [RES_W-1:0] word,
  output logic [7:0]       byte_out,
  output logic             last
);

  localparam int NB = RES_W / 8;
  localparam int CW = $clog2(NB) + 1;

  logic [RES_W-1:0] sreg;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= word;
      cnt  <= '0;
    end else if (advance) begin
      sreg <= sreg << 8;
      cnt  <= cnt + CW'(1);
    end
  end

  assign byte_out = sreg[RES_W-1 -: 8];
  assign last     = (cnt == CW'(NB - 1));

endmodule
`default_nettype wire

// File: rtl/spi_frame_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_frame_engine : SPI command decoder streaming image bytes to/from BRAM, |
// |                    starting PDI and returning result words.     Rev 1.0    |
// +----------------------------------------------------------------------------+
module spi_frame_engine
  import spi_frame_pkg::*;
#(
  parameter int ADDR_W  = 17,
  parameter int CH_N    = 3,
  parameter int CH_W    = 2,
  parameter int RES_N   = 4,
  parameter int RES_W   = 32,
  parameter int MAX_PIX = 76800
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spi_cycle_done,
  input  logic                   spi_cs_n,
  input  logic [7:0]             spi_byte_in,
  output logic [7:0]             spi_byte_out,
  output logic [ADDR_W-1:0]      bram_addr,
  output logic [CH_W-1:0]        bram_channel,
  output logic                   bram_we,
  output logic [7:0]             bram_data_in,
  input  logic [7:0]             bram_data_out,
  input  logic [RES_N*RES_W-1:0] results,
  output logic                   pdi_start,
  input  logic                   pdi_done,
  output logic                   err,
  output logic [2:0]             state
);

  localparam int LW = ADDR_W + 1;

  state_t          state_q, state_nxt;
  logic [7:0]      byte_q, byte_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [CH_W-1:0] ch_nxt;
  logic            we_nxt, start_nxt, err_nxt;
  logic [7:0]      wdata_nxt;
  logic [LW-1:0]   flen_q, flen_nxt, rem_q, rem_nxt;
  logic [1:0]      szcnt_q, szcnt_nxt;
  logic [23:0]     szsr_q, szsr_nxt;
  logic            ser_load, ser_adv, ser_last;
  logic [7:0]      ser_byte;
  logic [3:0]      opcode, arg;
  logic            ch_ok, idx_ok;
  logic [31:0]     len;
  logic [7:0]      status;

  assign opcode = spi_byte_in[7:4];
  assign arg    = spi_byte_in[3:0];
  assign ch_ok  = (arg != 4'd0) && ({1'b0, arg} <= 5'(CH_N));
  assign idx_ok = ({1'b0, arg} < 5'(RES_N));
  assign len    = {16'd0, szsr_q[23:8]} * {16'd0, szsr_q[7:0], spi_byte_in};

  spi_word_serializer #(.RES_W(RES_W)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .advance  (ser_adv),
    .word     (results[arg*RES_W +: RES_W]),
    .byte_out (ser_byte),
    .last     (ser_last)
  );

  always_comb begin
    state_nxt = state_q;
    byte_nxt  = byte_q;
    addr_nxt  = bram_addr;
    ch_nxt    = bram_channel;
    we_nxt    = 1'b0;
    wdata_nxt = bram_data_in;
    start_nxt = 1'b0;
    err_nxt   = err;
    flen_nxt  = flen_q;
    rem_nxt   = rem_q;
    szcnt_nxt = szcnt_q;
    szsr_nxt  = szsr_q;
    ser_load  = 1'b0;
    ser_adv   = 1'b0;
    status                             = '0;
    status[STAT_RUN_BIT]               = (state_q == ST_RUN);
    status[STAT_ERR_BIT]               = err;
    status[STAT_STATE_LSB +: 3]        = state_q;

    case (state_q)
      ST_IDLE: if (spi_cycle_done) begin
        case (opcode)
          OP_NOP: ;
          OP_WRCH: if (!ch_ok) err_nxt = 1'b1;
                   else begin
                     ch_nxt    = arg[CH_W-1:0];
                     szcnt_nxt = 2'd0;
                     state_nxt = ST_SIZE;
                   end
          OP_RDCH: if (!ch_ok || flen_q == '0) err_nxt = 1'b1;
                   else begin
                     ch_nxt    = arg[CH_W-1:0];
                     addr_nxt  = '0;
                     rem_nxt   = flen_q;
                     state_nxt = ST_READ;
                   end
          OP_RUN: begin
            start_nxt = 1'b1;
            byte_nxt  = RUN_BUSY;
            state_nxt = ST_RUN;
          end
          OP_RES: if (!idx_ok) err_nxt = 1'b1;
                  else begin
                    ser_load  = 1'b1;
                    state_nxt = ST_RES;
                  end
          // Status reports the error flag as it was, then clears it.
          OP_STAT: begin
            byte_nxt = status;
            err_nxt  = 1'b0;
          end
          default: err_nxt = 1'b1;
        endcase
      end
      ST_SIZE: if (spi_cs_n) state_nxt = ST_IDLE;
      else if (spi_cycle_done) begin
        if (szcnt_q == 2'd3) begin
          if (len == 32'd0 || len > 32'(MAX_PIX)) begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            flen_nxt  = len[LW-1:0];
            rem_nxt   = len[LW-1:0];
            addr_nxt  = '0;
            state_nxt = ST_WRITE;
          end
        end else begin
          szsr_nxt  = {szsr_q[15:0], spi_byte_in};
          szcnt_nxt = szcnt_q + 2'd1;
        end
      end
      ST_WRITE: if (spi_cs_n) state_nxt = ST_IDLE;
      else if (spi_cycle_done) begin
        we_nxt    = 1'b1;
        wdata_nxt = spi_byte_in;
        addr_nxt  = (rem_q == flen_q) ? '0 : bram_addr + ADDR_W'(1);
        rem_nxt   = rem_q - LW'(1);
        if (rem_q == LW'(1)) state_nxt = ST_IDLE;
      end
      // Address advances right after each byte so BRAM data is ready by the next one.
      ST_READ: if (spi_cs_n) state_nxt = ST_IDLE;
      else if (spi_cycle_done) begin
        byte_nxt = bram_data_out;
        addr_nxt = bram_addr + ADDR_W'(1);
        rem_nxt  = rem_q - LW'(1);
        if (rem_q == LW'(1)) state_nxt = ST_IDLE;
      end
      ST_RUN: if (pdi_done) begin
        byte_nxt  = RUN_DONE;
        state_nxt = ST_IDLE;
      end
      ST_RES: if (spi_cs_n) state_nxt = ST_IDLE;
      else if (spi_cycle_done) begin
        if (ser_last) state_nxt = ST_IDLE;
        else          ser_adv   = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      byte_q       <= '0;
      bram_addr    <= '0;
      bram_channel <= '0;
      bram_we      <= 1'b0;
      bram_data_in <= '0;
      pdi_start    <= 1'b0;
      err          <= 1'b0;
      flen_q       <= '0;
      rem_q        <= '0;
      szcnt_q      <= '0;
      szsr_q       <= '0;
    end else begin
      state_q      <= state_nxt;
      byte_q       <= byte_nxt;
      bram_addr    <= addr_nxt;
      bram_channel <= ch_nxt;
      bram_we      <= we_nxt;
      bram_data_in <= wdata_nxt;
      pdi_start    <= start_nxt;
      err          <= err_nxt;
      flen_q       <= flen_nxt;
      rem_q        <= rem_nxt;
      szcnt_q      <= szcnt_nxt;
      szsr_q       <= szsr_nxt;
    end
  end

  assign spi_byte_out = (state_q == ST_RES) ? ser_byte : byte_q;
  assign state        = state_q;

endmodule
`default_nettype wire
